// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Produces per-stage-register hold (stall_o) and bubble (flush_o) controls,
// resolving exceptions, data-memory waits, multi-cycle divide, load-use
// hazards and fetch waits by fixed priority. Also tracks divide occupancy
// and keeps a saturating count of stalled cycles.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_i,
  input  logic        dmem_busy_i,
  input  logic        div_start_i,
  input  logic        load_use_i,
  input  logic        imem_busy_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        div_busy_o,
  output logic        div_abort_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic {
    RUN = 1'b0,
    DIV = 1'b1
  } state_t;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] cnt;
  logic [5:0] cnt_next;

  assign div_busy_o = (state == DIV);

  // Fixed-priority hazard resolution; exactly one case drives the controls
  always_comb begin
    stall_o     = 5'b00000;
    flush_o     = 5'b00000;
    div_abort_o = 1'b0;
    if (rst) begin
      flush_o = 5'b11110;
    end else if (exc_i) begin
      flush_o     = 5'b11110;
      div_abort_o = (state == DIV);
    end else if (dmem_busy_i) begin
      stall_o = 5'b01111;
      flush_o = 5'b10000;
    end else if (state == DIV && cnt != 6'd0) begin
      stall_o = 5'b00111;
      flush_o = 5'b01000;
    end else if (load_use_i) begin
      stall_o = 5'b00011;
      flush_o = 5'b00100;
    end else if (imem_busy_i) begin
      stall_o = 5'b00001;
      flush_o = 5'b00010;
    end
  end

  // Divide sequencing: count down, then release once memory is not holding EX/MEM
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (exc_i) begin
      state_next = RUN;
      cnt_next   = 6'd0;
    end else begin
      case (state)
        RUN: begin
          if (div_start_i) begin
            state_next = DIV;
            cnt_next   = DIV_LOAD;
          end
        end
        DIV: begin
          if (cnt != 6'd0) begin
            cnt_next = cnt - 6'd1;
          end else if (!dmem_busy_i) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 6'd0;
        end
      endcase
    end
  end

  // State and divide counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Saturating count of cycles in which any stage register was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
    end else if ((stall_o != 5'b00000) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard testbench for pipe_ctrl: a driver issues stimulus and pushes the
// reference model's expected response; a monitor pops and compares each cycle.
module tb_pipe_ctrl;

  localparam int DivCycles = 4;

  logic        clk = 1'b0;
  logic        rst, excI, dmemBusyI, divStartI, loadUseI, imemBusyI;
  logic [4:0]  stallO, flushO;
  logic        divBusyO, divAbortO;
  logic [31:0] stallCntO;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        abort;
    logic        busy;
    logic [31:0] cnt;
  } expT;

  expT expQ[$];

  // Reference model: divide tracked by absolute cycle of earliest release
  bit              mInDiv = 1'b0;
  longint          mReleaseAt = 0;
  longint          mCycle = 0;
  longint unsigned mStallCnt = 0;

  pipe_ctrl #(.DIV_CYCLES(DivCycles)) dut (
    .clk(clk),
    .rst(rst),
    .exc_i(excI),
    .dmem_busy_i(dmemBusyI),
    .div_start_i(divStartI),
    .load_use_i(loadUseI),
    .imem_busy_i(imemBusyI),
    .stall_o(stallO),
    .flush_o(flushO),
    .div_busy_o(divBusyO),
    .div_abort_o(divAbortO),
    .stall_cnt_o(stallCntO)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the response, then advance the model
  task automatic applyStimulus(input bit r, input bit e, input bit dm, input bit dv,
                               input bit lu, input bit im);
    expT x;
    @(posedge clk);
    #1;
    rst = r; excI = e; dmemBusyI = dm; divStartI = dv; loadUseI = lu; imemBusyI = im;
    x.stall = 5'b00000;
    x.flush = 5'b00000;
    x.abort = 1'b0;
    x.busy  = mInDiv;
    x.cnt   = 32'(mStallCnt);
    if (r) x.flush = 5'b11110;
    else if (e) begin
      x.flush = 5'b11110;
      x.abort = mInDiv;
    end
    else if (dm) begin x.stall = 5'b01111; x.flush = 5'b10000; end
    else if (mInDiv && mCycle < mReleaseAt) begin x.stall = 5'b00111; x.flush = 5'b01000; end
    else if (lu) begin x.stall = 5'b00011; x.flush = 5'b00100; end
    else if (im) begin x.stall = 5'b00001; x.flush = 5'b00010; end
    expQ.push_back(x);
    if (r) begin
      mInDiv = 1'b0;
      mStallCnt = 0;
    end else begin
      if (x.stall != 5'b00000 && mStallCnt < 64'hFFFF_FFFF) mStallCnt = mStallCnt + 1;
      if (e) mInDiv = 1'b0;
      else if (!mInDiv) begin
        if (dv) begin
          mInDiv = 1'b1;
          mReleaseAt = mCycle + DivCycles;
        end
      end else if (mCycle >= mReleaseAt && !dm) mInDiv = 1'b0;
    end
    mCycle++;
  endtask

  // Monitor: compare each presented cycle against the oldest expectation
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("stall", 32'(stallO), 32'(e.stall));
        checkOutput("flush", 32'(flushO), 32'(e.flush));
        checkOutput("abort", 32'(divAbortO), 32'(e.abort));
        checkOutput("divBusy", 32'(divBusyO), 32'(e.busy));
        checkOutput("stallCnt", stallCntO, e.cnt);
        checkOutput("overlap", 32'(stallO & flushO), 32'd0);
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int waitCycles;
    rst = 1'b1; excI = 1'b0; dmemBusyI = 1'b0; divStartI = 1'b0; loadUseI = 1'b0; imemBusyI = 1'b0;
    $display("[TB] start");

    // Reset with all inputs high, then idle
    applyStimulus(1, 1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1, 1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

    // Plain divide
    applyStimulus(0, 0, 0, 1, 0, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);

    // Divide with memory wait at T+3..T+5
    applyStimulus(0, 0, 0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    // Exception mid-divide, then exception colliding with a divide start
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

    // Priority sweep
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 1, 1);
    applyStimulus(0, 1, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Reset mid-divide
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(99) < 25,
                    $urandom_range(99) < 12, $urandom_range(99) < 20, $urandom_range(99) < 25);
    end

    // Counter saturation: clean state, preload, then stall repeatedly
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    force dut.stall_cnt_o = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_o;
    mStallCnt = 64'hFFFF_FFFE;
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    @(posedge clk);
    if (expQ.size() > 0) begin
      bad++;
      total++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
